// File: rtl/stream_adder_pipe.sv
// rtl/stream_adder_pipe.sv - registered stream adder with skid buffer, saturation and packet status
//
// Adds a per-packet offset to every beat of a valid/ready/last stream.
// One cycle of latency, full throughput through an output register plus
// one skid register. The offset is taken from add_value on the first beat
// of each packet and held for the remaining beats.
//
// Ports:
//   sys_clk, sys_rst   rising-edge clock, asynchronous active-high reset
//   add_value          offset, sampled on the first beat of each packet
//   clear              synchronous pulse: zero packet_count, clear overflow
//   sink_*             input stream (valid/ready/last/data)
//   source_*           output stream (valid/ready/last/data)
//   overflow           sticky flag: some accepted beat produced a carry
//   packet_count       packets whose last beat has left on source
module stream_adder_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int SATURATE   = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [DATA_WIDTH-1:0] add_value,
    input  logic                  clear,
    input  logic                  sink_valid,
    input  logic                  sink_last,
    input  logic [DATA_WIDTH-1:0] sink_data,
    output logic                  sink_ready,
    output logic                  source_valid,
    output logic                  source_last,
    output logic [DATA_WIDTH-1:0] source_data,
    input  logic                  source_ready,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  packet_count
);

    logic                  in_packet;
    logic [DATA_WIDTH-1:0] offset_q;
    logic [DATA_WIDTH-1:0] offset;
    logic                  skid_full;
    logic                  skid_last;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [DATA_WIDTH:0]   sum;
    logic                  carry;
    logic [DATA_WIDTH-1:0] result;
    logic                  accept;
    logic                  out_xfer;
    logic                  out_free;

    // sink_ready comes straight from the skid flag, so it never depends on
    // source_ready within the same cycle.
    assign sink_ready = !skid_full;
    assign accept     = sink_valid && sink_ready;
    assign out_xfer   = source_valid && source_ready;
    // The output register can take a new beat if it is empty or being drained.
    assign out_free   = !source_valid || source_ready;

    always_comb begin
        offset = in_packet ? offset_q : add_value;
        sum    = {1'b0, sink_data} + {1'b0, offset};
        carry  = sum[DATA_WIDTH];
        result = sum[DATA_WIDTH-1:0];
        if ((SATURATE != 0) && carry) begin
            result = '1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            in_packet    <= 1'b0;
            offset_q     <= '0;
            skid_full    <= 1'b0;
            skid_last    <= 1'b0;
            skid_data    <= '0;
            source_valid <= 1'b0;
            source_last  <= 1'b0;
            source_data  <= '0;
            overflow     <= 1'b0;
            packet_count <= '0;
        end else begin
            if (accept) begin
                in_packet <= !sink_last;
                if (!in_packet) begin
                    offset_q <= add_value;
                end
            end

            // A full skid blocks accept, so skid refill and new-beat load
            // never compete for the output register.
            if (out_free) begin
                if (skid_full) begin
                    source_data  <= skid_data;
                    source_last  <= skid_last;
                    source_valid <= 1'b1;
                    skid_full    <= 1'b0;
                end else if (accept) begin
                    source_data  <= result;
                    source_last  <= sink_last;
                    source_valid <= 1'b1;
                end else begin
                    source_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_data <= result;
                skid_last <= sink_last;
                skid_full <= 1'b1;
            end

            if (clear) begin
                overflow <= 1'b0;
            end else if (accept && carry) begin
                overflow <= 1'b1;
            end

            if (clear) begin
                packet_count <= '0;
            end else if (out_xfer && source_last) begin
                packet_count <= packet_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_adder_pipe.sv
// tb/tb_stream_adder_pipe.sv - self-checking bench for stream_adder_pipe
module tb_stream_adder_pipe;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] add_value = 8'h00;
    logic       clear = 1'b0;
    logic       sink_valid = 1'b0;
    logic       sink_last = 1'b0;
    logic [7:0] sink_data = 8'h00;
    logic       source_ready = 1'b1;

    logic        ready0, valid0, last0, ovf0;
    logic [7:0]  data0;
    logic [15:0] cnt0;
    logic        ready1, valid1, last1, ovf1;
    logic [7:0]  data1;
    logic [3:0]  cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_adder_pipe #(.DATA_WIDTH(8), .SATURATE(0), .CNT_WIDTH(16)) dut0 (
        .sys_clk(clk), .sys_rst(sys_rst), .add_value(add_value), .clear(clear),
        .sink_valid(sink_valid), .sink_last(sink_last), .sink_data(sink_data),
        .sink_ready(ready0), .source_valid(valid0), .source_last(last0),
        .source_data(data0), .source_ready(source_ready), .overflow(ovf0),
        .packet_count(cnt0));

    stream_adder_pipe #(.DATA_WIDTH(8), .SATURATE(1), .CNT_WIDTH(4)) dut1 (
        .sys_clk(clk), .sys_rst(sys_rst), .add_value(add_value), .clear(clear),
        .sink_valid(sink_valid), .sink_last(sink_last), .sink_data(sink_data),
        .sink_ready(ready1), .source_valid(valid1), .source_last(last1),
        .source_data(data1), .source_ready(source_ready), .overflow(ovf1),
        .packet_count(cnt1));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [7:0] w;
        logic [7:0] s;
        logic       l;
    } beat_t;

    beat_t       q[$];
    int          log0[$];
    int          log1[$];
    logic        m_inpkt = 1'b0;
    logic [7:0]  m_off = 8'h00;
    logic        m_ovf = 1'b0;
    logic [15:0] m_cnt = 16'h0;

    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            q.delete();
            log0.delete();
            log1.delete();
            m_inpkt = 1'b0;
            m_off   = 8'h00;
            m_ovf   = 1'b0;
            m_cnt   = 16'h0;
        end else begin
            automatic bit acc  = sink_valid && (q.size() < 2);
            automatic bit xfer = (q.size() > 0) && source_ready;
            automatic int sum;
            automatic logic [7:0] off;
            automatic beat_t b;
            if (xfer) begin
                if (q[0].l) m_cnt = m_cnt + 16'd1;
                log0.push_back(int'(data0));
                log1.push_back(int'(data1));
                void'(q.pop_front());
            end
            if (acc) begin
                off = m_inpkt ? m_off : add_value;
                if (!m_inpkt) m_off = add_value;
                sum = int'(sink_data) + int'(off);
                b.w = sum[7:0];
                b.s = (sum > 255) ? 8'hFF : sum[7:0];
                b.l = sink_last;
                if (sum > 255) m_ovf = 1'b1;
                m_inpkt = !sink_last;
                q.push_back(b);
            end
            if (clear) begin
                m_cnt = 16'h0;
                m_ovf = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!sys_rst) begin
            chk("valid0", valid0, q.size() > 0);
            chk("valid1", valid1, q.size() > 0);
            chk("ready0", ready0, q.size() < 2);
            chk("ready1", ready1, q.size() < 2);
            if (q.size() > 0) begin
                chk("data_wrap", data0, q[0].w);
                chk("data_sat", data1, q[0].s);
                chk("last0", last0, q[0].l);
                chk("last1", last1, q[0].l);
            end
            chk("ovf0", ovf0, m_ovf);
            chk("ovf1", ovf1, m_ovf);
            chk("cnt0", cnt0, m_cnt);
            chk("cnt1", cnt1, m_cnt[3:0]);
        end
    end

    // ---------------- source_ready pattern ----------------
    int       rmode = 0;
    int       ph = 0;
    bit [4:0] pat = 5'b11001;   // bit0 first: 1,0,0,1,1

    always @(negedge clk) begin
        if (rmode == 1) begin
            source_ready = pat[ph];
            ph = (ph + 1) % 5;
        end else if (rmode == 2) begin
            source_ready = 1'b0;
        end else begin
            source_ready = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] d, input logic l);
        int  n = 0;
        logic acc;
        sink_valid = 1'b1;
        sink_data  = d;
        sink_last  = l;
        do begin
            acc = ready0;
            @(negedge clk);
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        sink_valid = 1'b0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic log_at(input string name, input int idx, input int exp);
        chk(name, (idx < log0.size()) ? log0[idx] : -1, exp);
    endtask

    initial begin
        int e1w[4];
        int e1s[4];
        int e3[6];
        e1w = '{8'h05, 8'h06, 8'h07, 8'h04};
        e1s = '{8'h05, 8'h06, 8'h07, 8'hFF};
        e3  = '{8'h15, 8'h25, 8'h35, 8'h45, 8'h11, 8'h12};

        repeat (3) @(negedge clk);
        chk("rst_valid", valid0, 0);
        chk("rst_ready", ready0, 1);
        chk("rst_data", data0, 0);
        chk("rst_cnt", cnt0, 0);
        sys_rst = 1'b0;
        @(negedge clk);

        // 1/2: wrap and saturate
        add_value = 8'h05;
        send(8'h00, 0); send(8'h01, 0); send(8'h02, 0); send(8'hFF, 1);
        drain();
        chk("t1_len", log0.size(), 4);
        for (int k = 0; k < 4; k++) begin
            log_at("t1_wrap", k, e1w[k]);
            chk("t2_sat", (k < log1.size()) ? log1[k] : -1, e1s[k]);
        end
        chk("t1_ovf0", ovf0, 1);
        chk("t2_ovf1", ovf1, 1);
        chk("t1_cnt", cnt0, 1);

        // 3: offset latched per packet
        log0.delete();
        add_value = 8'h05;
        send(8'h10, 0);
        add_value = 8'h10;
        send(8'h20, 0); send(8'h30, 0); send(8'h40, 1);
        send(8'h01, 0); send(8'h02, 1);
        drain();
        for (int k = 0; k < 6; k++) log_at("t3_offset", k, e3[k]);

        // 4: backpressure through skid
        log0.delete();
        add_value = 8'h20;
        rmode = 1;
        for (int i = 0; i < 16; i++) send(8'(i * 3), (i == 7) || (i == 15));
        drain();
        rmode = 0;
        chk("t4_len", log0.size(), 16);
        for (int k = 0; k < 16; k++) log_at("t4_seq", k, (k * 3 + 8'h20) & 8'hFF);

        // 5: reset mid-packet with skid full
        rmode = 2;
        @(negedge clk);
        add_value = 8'hF0;
        send(8'hA0, 0); send(8'hA1, 0);
        sink_valid = 1'b0;
        chk("t5_skid_full", ready0, 0);
        #2 sys_rst = 1'b1;
        #1;
        chk("t5_valid", valid0, 0);
        chk("t5_ready", ready0, 1);
        chk("t5_data", data0, 0);
        chk("t5_last", last0, 0);
        chk("t5_ovf", ovf0, 0);
        chk("t5_cnt", cnt1, 0);
        @(negedge clk);
        sys_rst = 1'b0;
        rmode = 0;
        @(negedge clk);
        add_value = 8'h33;
        send(8'h01, 1);
        drain();
        log_at("t5_first", 0, 8'h34);

        // 6: clear coinciding with the wrapping last-beat transfer
        add_value = 8'h01;
        for (int i = 0; i < 14; i++) send(8'hFF, 1);
        drain();
        chk("t6_cnt_pre", cnt1, 4'hF);
        chk("t6_ovf_pre", ovf0, 1);
        send(8'h10, 1);
        sink_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t6_cnt0", cnt0, 0);
        chk("t6_cnt1", cnt1, 0);
        chk("t6_ovf", ovf0, 0);
        send(8'h20, 1);
        drain();
        chk("t6_next", cnt1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
